// File: rtl/md_unit_ctrl_if.sv
// md_unit_ctrl_if: E/D-stage multiply/divide and HI/LO access bundle
// Signals (named from the unit's side):
//   i_start, i_op[1:0]   mult/div launch pulse and opcode (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   i_mt_hi, i_mt_lo     MTHI/MTLO write strobes
//   i_src_a, i_src_b     forwarded rs/rt operands (i_src_a is also MTHI/MTLO data)
//   i_md_use_d           D-stage instruction touches the mult/div unit or HI/LO
//   o_busy, o_hi, o_lo   operation in progress, HI/LO registers
//   o_md_stall           stall request to the hazard logic
// Modports: master = pipeline side, slave = md_unit_ctrl.
interface md_unit_ctrl_if;
    logic        i_start;
    logic [1:0]  i_op;
    logic        i_mt_hi;
    logic        i_mt_lo;
    logic [31:0] i_src_a;
    logic [31:0] i_src_b;
    logic        i_md_use_d;
    logic        o_busy;
    logic [31:0] o_hi;
    logic [31:0] o_lo;
    logic        o_md_stall;
    modport master (
        output i_start, i_op, i_mt_hi, i_mt_lo, i_src_a, i_src_b, i_md_use_d,
        input  o_busy, o_hi, o_lo, o_md_stall
    );
    modport slave (
        input  i_start, i_op, i_mt_hi, i_mt_lo, i_src_a, i_src_b, i_md_use_d,
        output o_busy, o_hi, o_lo, o_md_stall
    );
endinterface

// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: fixed-latency multiply/divide sequencer and HI/LO register owner
// Ports:
//   i_clk    system clock, rising edge
//   i_reset  asynchronous active-high reset
//   md       md_unit_ctrl_if.slave (launch/MT strobes, operands, busy, HI/LO, stall)
// The result is computed combinationally at launch and held in r_pend; the busy
// window only models latency before it is committed to HI/LO.
module md_unit_ctrl #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input logic           i_clk,
    input logic           i_reset,
    md_unit_ctrl_if.slave md
);
    localparam int CW = $clog2((MUL_CYCLES > DIV_CYCLES ? MUL_CYCLES : DIV_CYCLES) + 1);
    typedef enum logic {IDLE, RUN} state_t;
    state_t         r_state, w_state_nxt;
    logic [CW-1:0]  r_cnt, w_cnt_nxt;
    logic [31:0]    r_hi, r_lo, w_hi_nxt, w_lo_nxt;
    logic [63:0]    r_pend, w_result, w_prod_s, w_prod_u;
    logic           r_commit, w_commit, w_launch;
    logic           w_sa, w_sb, w_b_zero;
    logic [31:0]    w_ua, w_ub, w_q_mag, w_r_mag, w_q_s, w_r_s, w_q_u, w_r_u;
    assign w_prod_s = 64'($signed(md.i_src_a)) * 64'($signed(md.i_src_b));
    assign w_prod_u = {32'b0, md.i_src_a} * {32'b0, md.i_src_b};
    // Signed divide on magnitudes: avoids the INT_MIN / -1 overflow trap and
    // yields 0x80000000 rem 0 for that case naturally.
    assign w_sa     = md.i_src_a[31];
    assign w_sb     = md.i_src_b[31];
    assign w_ua     = w_sa ? -md.i_src_a : md.i_src_a;
    assign w_ub     = w_sb ? -md.i_src_b : md.i_src_b;
    assign w_b_zero = md.i_src_b == 32'b0;
    assign w_q_mag  = w_b_zero ? 32'b0 : w_ua / w_ub;
    assign w_r_mag  = w_b_zero ? 32'b0 : w_ua % w_ub;
    assign w_q_s    = (w_sa ^ w_sb) ? -w_q_mag : w_q_mag;
    assign w_r_s    = w_sa ? -w_r_mag : w_r_mag;
    assign w_q_u    = w_b_zero ? 32'b0 : md.i_src_a / md.i_src_b;
    assign w_r_u    = w_b_zero ? 32'b0 : md.i_src_a % md.i_src_b;
    assign w_result = md.i_op == 2'b00 ? w_prod_s :
                      md.i_op == 2'b01 ? w_prod_u :
                      md.i_op == 2'b10 ? {w_r_s, w_q_s} : {w_r_u, w_q_u};
    assign w_commit = ~md.i_op[1] | ~w_b_zero;
    assign w_launch = (r_state == IDLE) & md.i_start;
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        if (r_state == IDLE) begin
            if (md.i_start) begin
                w_state_nxt = RUN;
                w_cnt_nxt   = md.i_op[1] ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
            end else begin
                w_hi_nxt = md.i_mt_hi ? md.i_src_a : r_hi;
                w_lo_nxt = md.i_mt_lo ? md.i_src_a : r_lo;
            end
        end else begin
            w_cnt_nxt = r_cnt - 1'b1;
            if (r_cnt == CW'(1)) begin
                w_state_nxt = IDLE;
                {w_hi_nxt, w_lo_nxt} = r_commit ? r_pend : {r_hi, r_lo};
            end
        end
    end
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_pend   <= '0;
            r_commit <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            if (w_launch) begin
                r_pend   <= w_result;
                r_commit <= w_commit;
            end
        end
    end
    assign md.o_busy     = r_state == RUN;
    assign md.o_hi       = r_hi;
    assign md.o_lo       = r_lo;
    // Covers the launch cycle too, so the next md instruction cannot reach E mid-operation.
    assign md.o_md_stall = md.i_md_use_d & (md.i_start | md.o_busy);
endmodule

// File: doc/md_unit_ctrl.md
Name: md_unit_ctrl

Overview:
Multi-cycle multiply/divide controller and HI/LO register owner for the 5-stage pipeline.
- Accepts MULT/MULTU/DIV/DIVU launches and MTHI/MTLO writes from the E stage.
- Sequences a fixed-latency busy window before committing HI/LO.
- Raises a stall request to the hazard logic while a D-stage multiply/divide-class instruction must wait.
- HI/LO read data feeds the E-stage result path for MFHI/MFLO.

Parameters:
MUL_CYCLES, 5, busy cycles for MULT/MULTU (>=1)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  E-stage mult/div launch, one-cycle pulse per instruction
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
mt_hi  input  1  E-stage MTHI write strobe
mt_lo  input  1  E-stage MTLO write strobe
src_a  input  32  forwarded rs value (multiplicand/dividend; MTHI/MTLO data)
src_b  input  32  forwarded rt value (multiplier/divisor)
md_use_d  input  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo
busy  output  1  operation in progress
hi  output  32  HI register
lo  output  32  LO register
md_stall  output  1  stall request to the hazard logic

Behaviour:
- Reset (async, any time, including mid-operation):
  - hi=0, lo=0, busy=0, cnt=0, state IDLE.
  - Pending results are discarded.
- States:
  - IDLE (cnt==0): busy=0.
  - RUN (cnt!=0): busy=1.
- Launch:
  - start sampled high in IDLE at cycle T.
  - The edge ending T loads cnt with MUL_CYCLES (op[1]==0) or DIV_CYCLES (op[1]==1).
  - The same edge latches the computed 64-bit result and a commit flag into pending registers.
- RUN:
  - cnt decrements each edge.
  - On the edge where cnt==1, hi/lo take the pending result if commit=1, and state returns to IDLE.
  - busy is high cycles T+1..T+N; new hi/lo are visible from cycle T+N+1.
- Arithmetic:
  - MULT: {hi,lo} = signed 64-bit product.
  - MULTU: {hi,lo} = unsigned 64-bit product.
  - DIV: lo = signed quotient, truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: unsigned quotient/remainder.
  - Divisor 0: commit=0; busy still runs the full DIV_CYCLES; hi/lo unchanged.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- MTHI/MTLO:
  - In IDLE with start=0, the edge writes src_a into hi (mt_hi) and/or lo (mt_lo).
  - Both strobes set: both registers are written.
  - No busy period.
- Conflicts:
  - start while busy: ignored.
  - mt_hi/mt_lo while busy: ignored.
  - start together with mt_*: start wins, mt ignored.
  - The pipeline guarantees none of these through md_stall; ignoring them is defensive only.
- md_stall = md_use_d & (start | busy), purely combinational.
  - It covers the cycle of launch, so the following md instruction never enters E while an operation is pending.
- hi/lo outputs are registered; no bypass of pending results.

Test Plan:
- Reset, then MULT src_a=0xFFFFFFFE (-2), src_b=3 at T -> busy high T+1..T+5; at T+6 hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 5 busy cycles hi=0xFFFFFFFE, lo=0x00000001.
- DIV -7/2, then DIVU 7/0 -> first: 10 busy cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; second: 10 busy cycles, hi/lo unchanged.
- md_use_d=1 held with start at T -> md_stall high T..T+N, low at T+N+1; with md_use_d=0, md_stall stays 0 throughout.
- mt_hi=1, src_a=0x12345678 while IDLE -> hi=0x12345678 next cycle; same strobe during busy -> hi unchanged; start+mt_lo same cycle -> lo gets the product only.
- Assert reset at cycle T+3 of a DIV -> busy=0, hi=lo=0 immediately; no later commit.
